// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared types and helpers for the PLL lock supervisor
package pll_sup_pkg;

    // Supervisor state encoding, also exported on state_dbg
    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } sup_state_t;

    // Increment that sticks at the all-ones value of a width-bit counter
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

    // Shared timer width: enough bits to count up to (largest cycle parameter - 1)
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// rtl/pll_lock_supervisor_sync_2ff.sv - two-flop bit synchroniser with async active-high reset
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification and staggered domain release
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_DOMAINS         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 8,
    parameter int CNT_WIDTH           = 8
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   restart_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic [CNT_WIDTH-1:0]   lock_loss_cnt,
    output logic [CNT_WIDTH-1:0]   retry_cnt,
    output logic [2:0]             state_dbg
);

    localparam int TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                    LOCK_STABLE_CYCLES, STAGGER_CYCLES);

    // Terminal timer values: each phase ends on the cycle the timer hits N-1
    localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] STAGGER_LAST = TW'(STAGGER_CYCLES - 1);

    localparam logic [NUM_DOMAINS-1:0] DOM_ALL = '1;

    logic                   lock_s;
    sup_state_t             state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic [CNT_WIDTH-1:0]   loss_q, loss_d;
    logic [CNT_WIDTH-1:0]   retry_q, retry_d;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Register bank: state, timer and every output are flops
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_PLL_RESET;
            timer_q   <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= DOM_ALL;
            ready_q   <= 1'b0;
            loss_q    <= '0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pll_rst_q <= pll_rst_d;
            dom_q     <= dom_d;
            ready_q   <= ready_d;
            loss_q    <= loss_d;
            retry_q   <= retry_d;
        end
    end

    // Next-state and next-output logic; any return to PLL_RESET re-asserts every reset
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pll_rst_d = pll_rst_q;
        dom_d     = dom_q;
        ready_d   = ready_q;
        loss_d    = loss_q;
        retry_d   = retry_q;

        if (restart_req) begin
            // Soft restart wins over a simultaneous loss or timeout and is not counted
            state_d   = ST_PLL_RESET;
            timer_d   = '0;
            pll_rst_d = 1'b1;
            dom_d     = DOM_ALL;
            ready_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_PLL_RESET: begin
                    pll_rst_d = 1'b1;
                    dom_d     = DOM_ALL;
                    ready_d   = 1'b0;
                    if (timer_q == RST_LAST) begin
                        state_d   = ST_WAIT_LOCK;
                        timer_d   = '0;
                        pll_rst_d = 1'b0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABILIZE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        retry_d   = CNT_WIDTH'(sat_inc(32'(retry_q), CNT_WIDTH));
                        state_d   = ST_PLL_RESET;
                        timer_d   = '0;
                        pll_rst_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                ST_STABILIZE: begin
                    // A glitch before release is not a loss: just re-wait with a fresh timeout
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = ST_RELEASE;
                        timer_d = '0;
                        dom_d   = DOM_ALL << 1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (!lock_s) begin
                        loss_d    = CNT_WIDTH'(sat_inc(32'(loss_q), CNT_WIDTH));
                        state_d   = ST_PLL_RESET;
                        timer_d   = '0;
                        pll_rst_d = 1'b1;
                        dom_d     = DOM_ALL;
                        ready_d   = 1'b0;
                    end else if (dom_q == '0) begin
                        state_d = ST_RUN;
                        timer_d = '0;
                        ready_d = 1'b1;
                    end else if (timer_q == STAGGER_LAST) begin
                        // Shifting in zeros from bit 0 keeps the release order strictly ascending
                        dom_d   = dom_q << 1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (!lock_s) begin
                        loss_d    = CNT_WIDTH'(sat_inc(32'(loss_q), CNT_WIDTH));
                        state_d   = ST_PLL_RESET;
                        timer_d   = '0;
                        pll_rst_d = 1'b1;
                        dom_d     = DOM_ALL;
                        ready_d   = 1'b0;
                    end else begin
                        dom_d   = '0;
                        ready_d = 1'b1;
                    end
                end

                default: begin
                    state_d   = ST_PLL_RESET;
                    timer_d   = '0;
                    pll_rst_d = 1'b1;
                    dom_d     = DOM_ALL;
                    ready_d   = 1'b0;
                end
            endcase
        end
    end

    assign pll_rst       = pll_rst_q;
    assign domain_rst    = dom_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_q;
    assign retry_cnt     = retry_q;
    assign state_dbg     = state_q;

endmodule
